alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue/writeback stage directly upstream of the 8-bit ALU. Holds an 8×8-bit register file, accepts register-to-register instructions over a valid/ready handshake, and drives the ALU's `a`/`b`/`op`/`alu_start`. It waits for `alu_done`, then writes the ALU `result` back into the register file. It also provides an external load port, a debug read port and sticky error flags.

## Interface
- `TIMEOUT`, 16: maximum WAIT cycles allowed for `alu_done` (≥2).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high; all state is cleared at the clock edge where it is sampled high.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer accepts; equals (state==IDLE) && !reset.
- `instr_op` in 6: ALU opcode; legal values 6'd0–6'd8.
- `instr_rd`, `instr_rs1`, `instr_rs2` in 3 each: destination and source register indices.
- `ld_en` in 1, `ld_addr` in 3, `ld_data` in 8: external register write.
- `rd_addr` in 3, `rd_data` out 8: combinational register read.
- `alu_a`, `alu_b` out 8, `alu_op` out 6: registered operands and opcode to the ALU.
- `alu_start` out 1: high for exactly one cycle per issued instruction.
- `alu_result` in 8, `alu_done` in 1: from the ALU.
- `wb_valid` out 1, `wb_addr` out 3, `wb_data` out 8: writeback strobe and value.
- `illegal_op` out 1, `timeout_err` out 1: sticky error flags.
- `err_clr` in 1: clears both sticky flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE.
- **IDLE.** On `instr_valid && instr_ready`:
  - If `instr_op > 8`: set `illegal_op`, stay in IDLE, issue nothing.
  - Otherwise: latch `alu_a = R[rs1]`, `alu_b = R[rs2]`, `alu_op = op`, `rd`; go to ISSUE.
  - NOT (op 7) still latches `alu_b` from rs2; the ALU ignores it.
- **ISSUE.** `alu_start = 1`; clear the wait counter; go to WAIT.
- **WAIT.**
  - On `alu_done`: capture `alu_result` into `wb_data`; go to WRITE.
  - Otherwise: increment the counter. If the counter reaches TIMEOUT−1 without `alu_done`: set `timeout_err`, go to IDLE with no writeback.
  - `alu_done` is ignored in every state except WAIT.
- **WRITE.** `wb_valid = 1`; `R[rd] <= wb_data`; go to IDLE.
- **Operand stability.** `alu_a`, `alu_b` and `alu_op` hold their values from ISSUE until the next accept.
- **Load port.** `ld_en` writes `R[ld_addr]` in any state.
  - If a WRITE-state writeback targets the same address in the same cycle, the writeback wins.
  - A load during ISSUE or WAIT does not alter the operands already latched.
- **Error flags.**
  - `err_clr` clears both flags.
  - If `err_clr` coincides with a new set event, the set wins.
- **Width rules.**
  - All data is 8 bits; the result is written exactly as returned, with no extension or saturation.
  - Opcodes are passed through unchanged.
- **Reset values.**
  - State IDLE; register file all 0x00.
  - `alu_a`, `alu_b`, `alu_op`, `wb_addr`, `wb_data` = 0.
  - `alu_start`, `wb_valid`, `illegal_op`, `timeout_err` = 0.
- **Reset mid-operation.** Abandons the instruction: no writeback, `alu_start` low, `instr_ready` = 1 in the first cycle after reset deasserts.

## Timing
- Accept in cycle T (IDLE).
- T+1 (ISSUE): `alu_start` = 1.
- A single-cycle registered ALU raises `alu_done` in T+2 (WAIT), and the result is captured at the end of T+2.
- T+3 (WRITE): `wb_valid` = 1; the register is updated at the end of T+3.
- T+4: IDLE, `instr_ready` = 1.
- Minimum 4 cycles per instruction. Each extra ALU latency cycle adds one cycle.
- `rd_data` reflects a write in the cycle after the write edge.
- `alu_start`, `wb_valid` and `instr_ready` are decoded from state (combinational). All other outputs are registered.
- If `instr_valid` is held high continuously, the next instruction is accepted at T+4.

## Test plan
- **ADD.** Reset; load R1=0x12, R2=0x05; issue ADD(op 0) rd=3 rs1=1 rs2=2 at cycle T. Required:
  - `alu_start` high only in T+1, with `alu_a`=0x12, `alu_b`=0x05.
  - `wb_valid` in T+3 with `wb_addr`=3, `wb_data`=0x17.
  - `rd_data`(3)=0x17 from T+4.
- **Back-to-back SUB and writeback collision.** Issue SUB(op 1) R4=R2−R1, then XOR(op 6) R3=R3^R1, with `instr_valid` held high. Required:
  - R4=0xF3 (wrap-around); second accept at T+4; R3=0x05.
  - Then issue an instruction with rd=3 and assert `ld_en` to R3 in its WRITE cycle: the writeback value wins.
- **Timeout.** ALU model never asserts `alu_done`. Required:
  - `timeout_err` rises after 16 WAIT cycles; no `wb_valid`; destination register unchanged; `instr_ready` returns.
  - `err_clr` clears the flag.
- **Illegal opcode.** Issue op 6'd16. Required: `illegal_op` = 1, no `alu_start`, `instr_ready` stays 1, register file unchanged.
- **Stale load and slow ALU.** ALU model with 3-cycle latency; assert `ld_en` to rs1 during WAIT. Required: the result uses the latched operand; `wb_valid` appears at T+5.
- **Reset mid-WAIT.** Assert `reset` during WAIT. Required: next cycle `alu_start`=0, all registers read 0x00, `instr_ready`=1 after reset deasserts, no `wb_valid`.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the 8-bit ALU: 8x8 register file, valid/ready
// instruction intake, operand issue, bounded wait for alu_done and writeback.
module alu_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs1,
  input  logic [2:0] instr_rs2,
  input  logic       ld_en,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [5:0] alu_op,
  output logic       alu_start,
  input  logic [7:0] alu_result,
  input  logic       alu_done,
  output logic       wb_valid,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       illegal_op,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int DATA_W = 8;
  localparam int OP_W   = 6;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [0:7];
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept;
  logic              op_ok;
  logic              timeout_hit;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op <= OP_W'(8);
  endfunction

  assign instr_ready = (state == IDLE) && !reset;
  assign alu_start   = (state == ISSUE);
  assign wb_valid    = (state == WRITE);
  assign rd_data     = regs[rd_addr];

  assign accept      = instr_valid && instr_ready;
  assign op_ok       = is_legal_op(instr_op);
  assign timeout_hit = (state == WAIT) && !alu_done && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal_op  <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // Load first so a same-cycle writeback to the same address overrides it.
      if (ld_en) begin
        regs[ld_addr] <= ld_data;
      end

      case (state)
        IDLE: begin
          if (accept && op_ok) begin
            alu_a   <= regs[instr_rs1];
            alu_b   <= regs[instr_rs2];
            alu_op  <= instr_op;
            wb_addr <= instr_rd;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            wb_data <= alu_result;
            state   <= WRITE;
          end else if (wait_cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          regs[wb_addr] <= wb_data;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Sticky flags: a new set event takes priority over err_clr.
      if (accept && !op_ok) begin
        illegal_op <= 1'b1;
      end else if (err_clr) begin
        illegal_op <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU with programmable latency, writeback
// scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] instr_op;
  logic [2:0] instr_rd, instr_rs1, instr_rs2;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       illegal_op, timeout_err, err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_op(illegal_op), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // Behavioural ALU: result registered at alu_start, alu_done after alu_lat
  // cycles; alu_lat == 0 means it never answers.
  int         alu_lat = 1;
  int         pend = 0;
  logic [7:0] alu_res_q = 8'h00;

  function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a & b;
      6'd3: return a | b;
      6'd4: return a << b[2:0];
      6'd5: return a >> b[2:0];
      6'd6: return a ^ b;
      6'd7: return ~a;
      default: return a;
    endcase
  endfunction

  assign alu_done   = (pend == 1);
  assign alu_result = alu_res_q;

  always @(posedge clk) begin
    if (reset) begin
      pend <= 0;
    end else if (alu_start) begin
      pend      <= alu_lat;
      alu_res_q <= alu_f(alu_op, alu_a, alu_b);
    end else if (pend > 0) begin
      pend <= pend - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writeback scoreboard
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wb_t;
  wb_t sb[$];

  always @(negedge clk) begin
    wb_t e;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got addr=%0d data=%0h, expected no writeback (t=%0t)",
                 wb_addr, wb_data, $time);
      end else begin
        e = sb.pop_front();
        check("sb_wb_addr", wb_addr, e.addr);
        check("sb_wb_data", wb_data, e.data);
      end
    end
  end

  logic [7:0] shadow [0:7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [7:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      tick();
      check($sformatf("%s_r%0d", name, i), rd_data, shadow[i]);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !instr_ready; i++) tick();
    check("wait_idle", instr_ready, 1'b1);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] a, b, exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{op: 6'd0, rd: 3'd5, rs1: 3'd6, rs2: 3'd7, a: 8'hFF, b: 8'h01, exp: 8'h00};
    vecs[1] = '{op: 6'd1, rd: 3'd0, rs1: 3'd1, rs2: 3'd2, a: 8'h00, b: 8'h01, exp: 8'hFF};
    vecs[2] = '{op: 6'd2, rd: 3'd7, rs1: 3'd0, rs2: 3'd1, a: 8'hF0, b: 8'h3C, exp: 8'h30};
    vecs[3] = '{op: 6'd3, rd: 3'd2, rs1: 3'd3, rs2: 3'd4, a: 8'hF0, b: 8'h0F, exp: 8'hFF};
    vecs[4] = '{op: 6'd6, rd: 3'd6, rs1: 3'd5, rs2: 3'd4, a: 8'hAA, b: 8'hFF, exp: 8'h55};
    vecs[5] = '{op: 6'd7, rd: 3'd1, rs1: 3'd2, rs2: 3'd3, a: 8'h0F, b: 8'h33, exp: 8'hF0};
    vecs[6] = '{op: 6'd8, rd: 3'd4, rs1: 3'd7, rs2: 3'd6, a: 8'h5A, b: 8'h11, exp: 8'h5A};

    reset = 1'b1; instr_valid = 1'b0; set_instr(6'd0, 3'd0, 3'd0, 3'd0);
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'h00; rd_addr = 3'd0; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_ready", instr_ready, 1'b0);
    check("rst_alu_start", alu_start, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", alu_op, 6'd0);
    check("rst_wb_addr", wb_addr, 3'd0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_illegal", illegal_op, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", instr_ready, 1'b1);
    check_regs("rst_regs");

    // ADD R3 = R1 + R2 with cycle-exact checks
    load(3'd1, 8'h12);
    load(3'd2, 8'h05);
    instr_valid = 1'b1; set_instr(6'd0, 3'd3, 3'd1, 3'd2);
    check("add_ready_T", instr_ready, 1'b1);
    push_exp(3'd3, 8'h17);
    tick();
    instr_valid = 1'b0;
    check("add_start_T1", alu_start, 1'b1);
    check("add_alu_a", alu_a, 8'h12);
    check("add_alu_b", alu_b, 8'h05);
    check("add_alu_op", alu_op, 6'd0);
    tick();
    check("add_start_T2", alu_start, 1'b0);
    check("add_wb_T2", wb_valid, 1'b0);
    tick();
    check("add_wb_T3", wb_valid, 1'b1);
    check("add_wb_addr", wb_addr, 3'd3);
    check("add_wb_data", wb_data, 8'h17);
    check("add_start_T3", alu_start, 1'b0);
    tick();
    check("add_ready_T4", instr_ready, 1'b1);
    shadow[3] = 8'h17;
    rd_chk("add_r3", 3'd3, 8'h17);

    // Back-to-back SUB then XOR with instr_valid held high
    instr_valid = 1'b1; set_instr(6'd1, 3'd4, 3'd2, 3'd1);
    push_exp(3'd4, 8'hF3);
    tick();
    set_instr(6'd6, 3'd3, 3'd3, 3'd1);
    check("b2b_ready_T1", instr_ready, 1'b0);
    tick();
    check("b2b_ready_T2", instr_ready, 1'b0);
    tick();
    check("b2b_ready_T3", instr_ready, 1'b0);
    tick();
    check("b2b_ready_T4", instr_ready, 1'b1);
    push_exp(3'd3, 8'h05);
    tick();
    instr_valid = 1'b0;
    wait_idle();
    shadow[4] = 8'hF3;
    shadow[3] = 8'h05;
    rd_chk("b2b_r4", 3'd4, 8'hF3);
    rd_chk("b2b_r3", 3'd3, 8'h05);

    // Load and writeback to the same register in the WRITE cycle
    instr_valid = 1'b1; set_instr(6'd0, 3'd3, 3'd1, 3'd2);
    push_exp(3'd3, 8'h17);
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("coll_wb_T3", wb_valid, 1'b1);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    shadow[3] = 8'h17;
    rd_chk("coll_r3", 3'd3, 8'h17);

    // Slow ALU (3 cycles) with a load to rs1 during WAIT
    alu_lat = 3;
    instr_valid = 1'b1; set_instr(6'd0, 3'd5, 3'd1, 3'd2);
    push_exp(3'd5, 8'h17);
    tick();
    instr_valid = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h80;
    tick();
    ld_en = 1'b0;
    check("stale_alu_a", alu_a, 8'h12);
    check("slow_wb_T3", wb_valid, 1'b0);
    tick();
    check("slow_wb_T4", wb_valid, 1'b0);
    tick();
    check("slow_wb_T5", wb_valid, 1'b1);
    tick();
    alu_lat = 1;
    shadow[1] = 8'h80;
    shadow[5] = 8'h17;
    rd_chk("slow_r5", 3'd5, 8'h17);
    rd_chk("slow_r1", 3'd1, 8'h80);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      load(vecs[v].rs1, vecs[v].a);
      load(vecs[v].rs2, vecs[v].b);
      wait_idle();
      instr_valid = 1'b1; set_instr(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2);
      push_exp(vecs[v].rd, vecs[v].exp);
      tick();
      instr_valid = 1'b0;
      wait_idle();
      shadow[vecs[v].rd] = vecs[v].exp;
      rd_chk($sformatf("vec%0d_rd", v), vecs[v].rd, vecs[v].exp);
    end

    // Illegal opcode
    instr_valid = 1'b1; set_instr(6'd16, 3'd0, 3'd1, 3'd2);
    tick();
    instr_valid = 1'b0;
    check("ill_flag", illegal_op, 1'b1);
    check("ill_no_start", alu_start, 1'b0);
    check("ill_ready", instr_ready, 1'b1);
    tick();
    check("ill_no_start2", alu_start, 1'b0);
    check_regs("ill_regs");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill_clr", illegal_op, 1'b0);
    instr_valid = 1'b1; err_clr = 1'b1; set_instr(6'd9, 3'd0, 3'd1, 3'd2);
    tick();
    instr_valid = 1'b0; err_clr = 1'b0;
    check("ill9_set_wins", illegal_op, 1'b1);
    check("ill9_no_start", alu_start, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill9_clr", illegal_op, 1'b0);

    // Timeout: ALU never answers
    alu_lat = 0;
    instr_valid = 1'b1; set_instr(6'd0, 3'd6, 3'd1, 3'd2);
    tick();
    instr_valid = 1'b0;
    n = 1;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    check("to_cycle", n, 18);
    check("to_flag", timeout_err, 1'b1);
    check("to_ready", instr_ready, 1'b1);
    check_regs("to_regs");
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", timeout_err, 1'b0);

    // Reset while waiting on the ALU
    instr_valid = 1'b1; set_instr(6'd0, 3'd7, 3'd1, 3'd2);
    tick();
    instr_valid = 1'b0;
    tick();
    check("rw_busy", instr_ready, 1'b0);
    reset = 1'b1;
    tick();
    check("rw_no_start", alu_start, 1'b0);
    check("rw_no_wb", wb_valid, 1'b0);
    for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
    check_regs("rw_regs");
    reset = 1'b0;
    #1;
    check("rw_ready", instr_ready, 1'b1);
    alu_lat = 1;
    tick(); tick(); tick();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
